mnist_infer_sched: RTL and testbench
====================================

MNIST_INFER_SCHED -- requirements
Module: mnist_infer_sched

Interface
REQ-001 Parameter TIMEOUT_CYC, default 2047: maximum cycles in WAIT_DONE before an inference is aborted.
REQ-002 Parameter TAG_W, default 4: width of the per-request tag.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  2  inference request, one bit per requester (0 = host loader, 1 = self-test).
REQ-006 req_tag  input  2*TAG_W  request tags; requester k occupies bits [k*TAG_W +: TAG_W].
REQ-007 req_ready  output  2  one-hot grant; the request is accepted when valid and ready are both high.
REQ-008 accel_start  output  1  start pulse to the accelerator core.
REQ-009 accel_img_sel  output  1  image-source select: the granted requester id, stable from START until RESP exits.
REQ-010 accel_done  input  1  accelerator done, level signal.
REQ-011 accel_digit  input  4  accelerator predicted digit, valid while accel_done is high.
REQ-012 rsp_valid / rsp_ready  output / input  1 / 1  result handshake.
REQ-013 rsp_id  output  1  requester id of the result.
REQ-014 rsp_tag  output  TAG_W  echoed tag of the result.
REQ-015 rsp_digit  output  4  result digit; 4'hF on timeout.
REQ-016 rsp_timeout  output  1  result was aborted by timeout.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 infer_cnt  output  16  count of completed (non-timeout) inferences.
REQ-019 timeout_cnt  output  8  count of timeouts.

Function
REQ-020 FSM states SHALL be IDLE, START, WAIT_DONE and RESP; the FSM SHALL take exactly one state transition per cycle.
REQ-021 In IDLE, req_ready SHALL be combinational and one-hot on a valid requester; it SHALL be 0 in all other states.
REQ-022 Arbitration SHALL be round-robin:
- If both requesters are valid, the one not granted last SHALL win.
- If one requester is valid, it SHALL win.
- last_grant SHALL update on each accepted request.
REQ-023 On acceptance, the FSM SHALL latch id and tag, clear the cycle counter, and move IDLE->START.
REQ-024 In START, accel_start SHALL be 1 for exactly one cycle; the next state SHALL be WAIT_DONE.
REQ-025 In WAIT_DONE, the FSM SHALL detect the rising edge of accel_done (accel_done=1 with previous-cycle value 0). On that edge it SHALL:
- capture accel_digit;
- set rsp_timeout=0;
- increment infer_cnt;
- move to RESP.
A done level already high when START occurs SHALL be ignored.
REQ-026 The WAIT_DONE counter SHALL increment every cycle. When it reaches TIMEOUT_CYC without a done edge, the FSM SHALL:
- set rsp_digit=4'hF and rsp_timeout=1;
- increment timeout_cnt, saturating at 255;
- move to RESP.
REQ-027 If a done edge and the timeout occur in the same cycle, done SHALL win.
REQ-028 In RESP, rsp_valid SHALL be 1 and all rsp_* fields SHALL be held stable until rsp_ready=1; the FSM SHALL then go to IDLE the next cycle.
REQ-029 A new request SHALL NOT be accepted in the cycle of the rsp handshake; the earliest acceptance is the following IDLE cycle.
REQ-030 infer_cnt SHALL wrap from 65535 to 0.
REQ-031 Latency from acceptance to accel_start SHALL be 1 cycle; from the done edge to rsp_valid SHALL be 1 cycle.
REQ-032 req_valid deasserting while the FSM is not in IDLE SHALL have no effect on the inference in flight.

Reset
REQ-033 While rst=0, the block SHALL asynchronously force:
- state=IDLE, last_grant=1 (so requester 0 wins first);
- accel_start=0, req_ready=0, rsp_valid=0, rsp_timeout=0, busy=0;
- rsp_digit=0, rsp_tag=0, rsp_id=0, accel_img_sel=0;
- infer_cnt=0, timeout_cnt=0, counters and edge register cleared.
REQ-034 Reset asserted mid-inference SHALL abort without issuing a response; accel_start SHALL fall immediately.
REQ-035 Release of reset SHALL be synchronous-safe; the first acceptance can occur on the first clk edge after rst goes high.

Verification
REQ-036 Single request: req_valid=01, tag=4'h3; accel_done rises 850 cycles after start with digit 6 -> one accel_start pulse, rsp_valid, rsp_id=0, rsp_tag=3, rsp_digit=6, rsp_timeout=0, infer_cnt=1.
REQ-037 Contention: req_valid=11 held for 4 inferences -> grants alternate 0,1,0,1; accel_img_sel matches each grant.
REQ-038 Timeout: no accel_done, TIMEOUT_CYC=2047 -> rsp_valid exactly 2047 cycles after entering WAIT_DONE; rsp_digit=F, rsp_timeout=1, timeout_cnt=1, infer_cnt unchanged.
REQ-039 Backpressure: rsp_ready=0 for 10 cycles -> rsp fields stable throughout, req_ready=0, no new accel_start; the handshake in cycle 11 returns to IDLE.
REQ-040 Stale done: accel_done held high from the previous run through START -> ignored; completion only on the next 0->1 edge.
REQ-041 Reset mid-WAIT_DONE: rst=0 at cycle 400 -> all outputs go to reset values asynchronously, no rsp_valid; after release, a request is accepted normally with requester 0 given priority.

Source files
------------

// File: rtl/mnist_infer_sched.sv
// rtl/mnist_infer_sched.sv - round-robin request scheduler for the MNIST inference accelerator
// Grants one of two requesters, starts the core, waits for a done edge or timeout, returns a tagged result.
module mnist_infer_sched #(
   parameter int TIMEOUT_CYC = 2047,
   parameter int TAG_W       = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         req_valid,
   input  logic [2*TAG_W-1:0] req_tag,
   output logic [1:0]         req_ready,
   output logic               accel_start,
   output logic               accel_img_sel,
   input  logic               accel_done,
   input  logic [3:0]         accel_digit,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_id,
   output logic [TAG_W-1:0]   rsp_tag,
   output logic [3:0]         rsp_digit,
   output logic               rsp_timeout,
   output logic               busy,
   output logic [15:0]        infer_cnt,
   output logic [7:0]         timeout_cnt
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {IDLE, START, WAIT_DONE, RESP} state_t;

   state_t             state_q, state_d;
   logic               last_q, last_d;
   logic               id_q, id_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               done_prev_q;
   logic [3:0]         digit_q, digit_d;
   logic               tmo_q, tmo_d;
   logic [15:0]        infer_cnt_q, infer_cnt_d;
   logic [7:0]         tmo_cnt_q, tmo_cnt_d;

   logic               grant_id;
   logic [1:0]         grant;
   logic               done_rise;
   logic [CNT_W-1:0]   cnt_inc;

   // Contention goes to whoever was not served last; reset masks the combinational grant.
   always_comb begin
      grant_id = 1'b0;
      if (req_valid == 2'b11) begin
         grant_id = ~last_q;
      end else if (req_valid[1]) begin
         grant_id = 1'b1;
      end
      grant = 2'b00;
      if (state_q == IDLE && rst && (|req_valid)) begin
         grant = grant_id ? 2'b10 : 2'b01;
      end
   end

   assign done_rise = accel_done & ~done_prev_q;
   assign cnt_inc   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      id_d        = id_q;
      tag_d       = tag_q;
      cnt_d       = cnt_q;
      digit_d     = digit_q;
      tmo_d       = tmo_q;
      infer_cnt_d = infer_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      case (state_q)
         IDLE: begin
            if (|grant) begin
               id_d    = grant_id;
               last_d  = grant_id;
               tag_d   = grant_id ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
               cnt_d   = '0;
               state_d = START;
            end
         end
         START: state_d = WAIT_DONE;
         WAIT_DONE: begin
            cnt_d = cnt_inc;
            // A done edge takes priority over a timeout landing in the same cycle.
            if (done_rise) begin
               digit_d     = accel_digit;
               tmo_d       = 1'b0;
               infer_cnt_d = infer_cnt_q + 16'd1;
               state_d     = RESP;
            end else if (cnt_inc == CNT_W'(TIMEOUT_CYC)) begin
               digit_d = 4'hF;
               tmo_d   = 1'b1;
               if (tmo_cnt_q != 8'hFF) begin
                  tmo_cnt_d = tmo_cnt_q + 8'd1;
               end
               state_d = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         id_q        <= 1'b0;
         tag_q       <= '0;
         cnt_q       <= '0;
         done_prev_q <= 1'b0;
         digit_q     <= 4'h0;
         tmo_q       <= 1'b0;
         infer_cnt_q <= 16'd0;
         tmo_cnt_q   <= 8'd0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         id_q        <= id_d;
         tag_q       <= tag_d;
         cnt_q       <= cnt_d;
         done_prev_q <= accel_done;
         digit_q     <= digit_d;
         tmo_q       <= tmo_d;
         infer_cnt_q <= infer_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
      end
   end

   assign req_ready     = grant;
   assign accel_start   = (state_q == START);
   assign accel_img_sel = id_q;
   assign rsp_valid     = (state_q == RESP);
   assign rsp_id        = id_q;
   assign rsp_tag       = tag_q;
   assign rsp_digit     = digit_q;
   assign rsp_timeout   = tmo_q;
   assign busy          = (state_q != IDLE);
   assign infer_cnt     = infer_cnt_q;
   assign timeout_cnt   = tmo_cnt_q;

endmodule

// File: tb/tb_mnist_infer_sched.sv
// tb/tb_mnist_infer_sched.sv - self-checking bench for mnist_infer_sched
// Directed and random inferences checked against a round-robin/counter reference model.
module tb_mnist_infer_sched;

   localparam int TAG_W = 4;
   localparam int TMO   = 2047;

   logic               clk = 1'b0;
   logic               rst;
   logic [1:0]         req_valid;
   logic [2*TAG_W-1:0] req_tag;
   logic [1:0]         req_ready;
   logic               accel_start;
   logic               accel_img_sel;
   logic               accel_done;
   logic [3:0]         accel_digit;
   logic               rsp_valid;
   logic               rsp_ready;
   logic               rsp_id;
   logic [TAG_W-1:0]   rsp_tag;
   logic [3:0]         rsp_digit;
   logic               rsp_timeout;
   logic               busy;
   logic [15:0]        infer_cnt;
   logic [7:0]         timeout_cnt;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int m_last  = 1;
   int m_infer = 0;
   int m_tmo   = 0;

   always #5 clk = ~clk;

   mnist_infer_sched #(.TIMEOUT_CYC(TMO), .TAG_W(TAG_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_tag      (req_tag),
      .req_ready    (req_ready),
      .accel_start  (accel_start),
      .accel_img_sel(accel_img_sel),
      .accel_done   (accel_done),
      .accel_digit  (accel_digit),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_id       (rsp_id),
      .rsp_tag      (rsp_tag),
      .rsp_digit    (rsp_digit),
      .rsp_timeout  (rsp_timeout),
      .busy         (busy),
      .infer_cnt    (infer_cnt),
      .timeout_cnt  (timeout_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int pick(input logic [1:0] v);
      if (v == 2'b11) return 1 - m_last;
      if (v == 2'b10) return 1;
      return 0;
   endfunction

   task automatic reset_checks(input string name);
      check({name, "_busy"}, busy, 0);
      check({name, "_start"}, accel_start, 0);
      check({name, "_ready"}, req_ready, 0);
      check({name, "_rsp_valid"}, rsp_valid, 0);
      check({name, "_rsp_timeout"}, rsp_timeout, 0);
      check({name, "_rsp_digit"}, rsp_digit, 0);
      check({name, "_rsp_tag"}, rsp_tag, 0);
      check({name, "_rsp_id"}, rsp_id, 0);
      check({name, "_img_sel"}, accel_img_sel, 0);
      check({name, "_infer_cnt"}, infer_cnt, 0);
      check({name, "_timeout_cnt"}, timeout_cnt, 0);
   endtask

   // dly < 0 means the core never finishes; stale keeps done high for the first WAIT_DONE cycles.
   task automatic infer(input logic [1:0] v, input logic [7:0] tags, input int dly,
                        input logic [3:0] dig, input int bp, input bit stale, input bit keep);
      int         g;
      int         k;
      int         exp_k;
      bit         exp_to;
      bit         ok;
      logic [3:0] exp_dig;
      logic [3:0] exp_tag;
      g = pick(v);
      req_valid = v;
      req_tag   = tags;
      rsp_ready = 1'b0;
      #1;
      check("req_ready_grant", req_ready, (g == 1) ? 2'b10 : 2'b01);
      tick();
      m_last    = g;
      req_valid = 2'($urandom);
      req_tag   = 8'($urandom);
      #1;
      check("accel_start_pulse", accel_start, 1);
      check("img_sel_start", accel_img_sel, g);
      check("req_ready_busy", req_ready, 0);
      check("busy_start", busy, 1);
      tick();
      check("accel_start_fall", accel_start, 0);
      k  = 0;
      ok = 1'b1;
      while (rsp_valid !== 1'b1 && k < 3000) begin
         req_valid = 2'($urandom);
         if (dly >= 0 && k >= dly) begin
            accel_done  = 1'b1;
            accel_digit = dig;
         end else begin
            accel_done  = stale && (k < 3);
            accel_digit = 4'($urandom);
         end
         #1;
         if (accel_img_sel !== g[0] || accel_start !== 1'b0 || req_ready !== 2'b00) ok = 1'b0;
         tick();
         k++;
      end
      exp_to  = (dly < 0) || (dly >= TMO);
      exp_k   = exp_to ? TMO : dly + 1;
      exp_tag = (g == 1) ? tags[7:4] : tags[3:0];
      if (exp_to) begin
         m_tmo   = (m_tmo < 255) ? m_tmo + 1 : 255;
         exp_dig = 4'hF;
      end else begin
         m_infer = (m_infer + 1) % 65536;
         exp_dig = dig;
      end
      check("wait_cycles", k, exp_k);
      check("wait_hold", ok, 1);
      check("rsp_valid", rsp_valid, 1);
      check("rsp_id", rsp_id, g);
      check("rsp_tag", rsp_tag, exp_tag);
      check("rsp_digit", rsp_digit, exp_dig);
      check("rsp_timeout", rsp_timeout, exp_to);
      check("infer_cnt", infer_cnt, m_infer);
      check("timeout_cnt", timeout_cnt, m_tmo);
      ok = 1'b1;
      for (int i = 0; i < bp; i++) begin
         req_valid   = 2'($urandom);
         accel_digit = 4'($urandom);
         #1;
         if (rsp_valid !== 1'b1 || rsp_digit !== exp_dig || rsp_tag !== exp_tag ||
             rsp_id !== g[0] || rsp_timeout !== exp_to || req_ready !== 2'b00 ||
             accel_start !== 1'b0) ok = 1'b0;
         tick();
      end
      check("bp_stable", ok, 1);
      check("bp_still_valid", rsp_valid, 1);
      rsp_ready = 1'b1;
      req_valid = 2'b11;
      #1;
      check("no_accept_in_handshake", req_ready, 0);
      tick();
      rsp_ready = 1'b0;
      req_valid = 2'b00;
      if (!keep) accel_done = 1'b0;
      #1;
      check("idle_after_rsp", busy, 0);
      check("rsp_dropped", rsp_valid, 0);
   endtask

   initial begin
      rst         = 1'b0;
      req_valid   = 2'b01;
      req_tag     = 8'h00;
      accel_done  = 1'b0;
      accel_digit = 4'h0;
      rsp_ready   = 1'b0;
      tick();
      tick();
      reset_checks("por");
      rst       = 1'b1;
      req_valid = 2'b00;

      infer(2'b01, 8'h03, 849, 4'd6, 0, 1'b0, 1'b0);
      check("single_infer_cnt", infer_cnt, 1);
      infer(2'b10, 8'h5A, 10, 4'd2, 0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         infer(2'b11, 8'($urandom), int'($urandom_range(0, 40)), 4'($urandom_range(0, 9)),
               0, 1'b0, 1'b0);
         check("rr_alternate", m_last, i % 2);
      end
      infer(2'b01, 8'h7C, -1, 4'd0, 0, 1'b0, 1'b0);
      infer(2'b10, 8'hE1, TMO - 1, 4'd9, 0, 1'b0, 1'b0);
      infer(2'b11, 8'h4B, 5, 4'd3, 10, 1'b0, 1'b1);
      infer(2'b01, 8'h2D, 20, 4'd8, 0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         infer(2'($urandom_range(1, 3)), 8'($urandom), int'($urandom_range(0, 60)),
               4'($urandom_range(0, 9)), int'($urandom_range(0, 3)), 1'b0, 1'b0);
      end

      req_valid = 2'b11;
      req_tag   = 8'h96;
      tick();
      #2;
      rst = 1'b0;
      #1;
      reset_checks("rst_in_start");
      tick();
      rst       = 1'b1;
      m_last    = 1;
      m_infer   = 0;
      m_tmo     = 0;
      req_valid = 2'b11;
      req_tag   = 8'h69;
      tick();
      for (int i = 0; i < 400; i++) tick();
      #2;
      rst = 1'b0;
      #1;
      reset_checks("rst_in_wait");
      begin
         bit quiet;
         quiet = 1'b1;
         for (int i = 0; i < 3; i++) begin
            accel_done = ~accel_done;
            tick();
            if (rsp_valid !== 1'b0) quiet = 1'b0;
         end
         check("no_rsp_in_reset", quiet, 1);
      end
      accel_done = 1'b0;
      rst        = 1'b1;
      m_last     = 1;
      m_infer    = 0;
      m_tmo      = 0;
      infer(2'b11, 8'hC5, 7, 4'd4, 1, 1'b0, 1'b0);
      check("post_reset_infer_cnt", infer_cnt, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
